mem_port_arbiter: RTL

Shares one memory-controller port (op / io_address / common data bus / tx_done / rd_valid) between NUM_REQ DMA-style requesters. Grants are round-robin, one whole transaction at a time. While a transaction is granted, the block muxes the winner's request onto the controller and routes the completion and read-valid strobes back to that requester only. It sits between the requesters and mem_cntrl.

---
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory-controller port between NUM_REQ
// requesters. Grants are round-robin and cover one whole transaction.
// GAP_CYCLES NOP cycles follow every completion before the next grant.
// Optional build macro ARB_STATS_EN adds per-requester completion counters
// (txn_count) with a synchronous clear input (stats_clr).
//
// state | meaning
// IDLE  | no owner, arbitrate among requesting ports
// OWN   | winner's op latched and driven, strobes routed back to the winner
// GAP   | post-completion NOP cycles, nothing forwarded
module mem_port_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*NUM_REQ-1:0]    req_op,
  input  logic [64*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]      req_tx_done,
  output logic [NUM_REQ-1:0]      req_rd_valid,
  output logic [31:0]             req_rdata,
  output logic [1:0]              mem_op,
  output logic [63:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_tx_done,
  input  logic                    mem_rd_valid,
  input  logic [31:0]             mem_rdata,
  output logic [NUM_REQ-1:0]      grant,
`ifdef ARB_STATS_EN
  input  logic                    stats_clr,
  output logic [16*NUM_REQ-1:0]   txn_count,
`endif
  output logic                    busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Gap timer is a down-counter loaded on completion; zero is terminal count.
  localparam logic [1:0] GAP_LOAD = (GAP_CYCLES > 0) ? 2'(GAP_CYCLES - 1) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

  state_t            state, state_nxt;
  logic [NUM_REQ-1:0] req_valid;
  logic [IW-1:0]     ptr, gidx, win_idx;
  logic              win_found;
  logic [1:0]        op_q;
  logic [1:0]        gap_cnt;
  int                scan_idx;

  // A port is requesting for READ (01) or WRITE (11); both have bit 0 set.
  always_comb begin
    req_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) req_valid[i] = req_op[2*i];
  end

  // Round-robin pick: first requesting port scanning upward from ptr+1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = (int'(ptr) + k) % NUM_REQ;
      if (!win_found && req_valid[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan_idx);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (win_found) state_nxt = S_OWN;
      S_OWN:  if (mem_tx_done) state_nxt = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
      S_GAP:  if (gap_cnt == 2'd0) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Grant, latched op, round-robin pointer and gap timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant   <= '0;
      gidx    <= '0;
      op_q    <= 2'b00;
      ptr     <= IW'(NUM_REQ - 1);
      gap_cnt <= 2'd0;
    end else begin
      if (state == S_IDLE && win_found) begin
        grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
        gidx  <= win_idx;
        op_q  <= req_op[2*win_idx +: 2];
      end
      if (state == S_OWN && mem_tx_done) begin
        ptr     <= gidx;
        grant   <= '0;
        gap_cnt <= GAP_LOAD;
      end
      if (state == S_GAP && gap_cnt != 2'd0) gap_cnt <= gap_cnt - 2'd1;
    end
  end

  // Controller-side mux and strobe routing; everything is quiet outside OWN.
  always_comb begin
    mem_op       = 2'b00;
    mem_addr     = '0;
    mem_wdata    = '0;
    req_tx_done  = '0;
    req_rd_valid = '0;
    if (state == S_OWN) begin
      mem_op             = op_q;
      mem_addr           = req_addr[64*gidx +: 64];
      mem_wdata          = req_wdata[32*gidx +: 32];
      req_rd_valid[gidx] = mem_rd_valid;
      req_tx_done[gidx]  = mem_tx_done;
    end
  end

  assign busy      = (state != S_IDLE);
  assign req_rdata = mem_rdata;

`ifdef ARB_STATS_EN
  // Saturating completion counters; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txn_count <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (stats_clr)
          txn_count[16*i +: 16] <= 16'd0;
        else if (req_tx_done[i] && txn_count[16*i +: 16] != 16'hFFFF)
          txn_count[16*i +: 16] <= txn_count[16*i +: 16] + 16'd1;
      end
    end
  end
`endif

endmodule
